// File: rtl/dps_utim64.sv
// rtl/dps_utim64.sv - 64-bit free-running user timer with compare, overflow and IRQ/ACK handshake
//
// Purpose:
//   Prescaled 64-bit up-counter with one compare channel (optionally periodic)
//   and overflow detection. MATCH/OVF flags feed a two-state IRQ machine whose
//   level output is held until the interrupt controller acknowledges it.
//
// Ports:
//   iCLOCK   in   1   system clock, rising edge
//   inRESET  in   1   asynchronous active-low reset
//   iREQ     in   1   register access request (one-cycle pulse)
//   iRW      in   1   1 = write, 0 = read
//   iADDR    in   3   register index
//   iDATA    in  32   write data
//   oVALID   out  1   response strobe, one cycle after iREQ
//   oDATA    out 32   read data (0 for writes / idle)
//   oIRQ     out  1   interrupt request level
//   iACK     in   1   interrupt acknowledge pulse
//
// Register map:
//   0 CTRL    [0] EN, [1] CLR (self-clearing, reads 0), [P_PRESCALE_W+7:8] DIV
//   1 CNT_L   read latches CNT[63:32] into the read shadow; write fills the write shadow
//   2 CNT_H   read returns the read shadow; write loads {iDATA, write shadow}
//   3 CMP_L   4 CMP_H
//   5 CMPCTRL [0] CMP_EN, [1] CMP_IE, [2] PERIODIC, [3] OVF_IE
//   6 FLAGS   [0] MATCH, [1] OVF, write-1-to-clear
//   7 reserved

module dps_utim64 #(
  parameter int P_PRESCALE_W = 8
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ,
  input  logic        iRW,
  input  logic [2:0]  iADDR,
  input  logic [31:0] iDATA,
  output logic        oVALID,
  output logic [31:0] oDATA,
  output logic        oIRQ,
  input  logic        iACK
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;

  logic                    r_en;
  logic [P_PRESCALE_W-1:0] r_div;
  logic [P_PRESCALE_W-1:0] r_presc;
  logic [63:0]             r_cnt;
  logic [63:0]             r_cmp;
  logic                    r_cmp_en;
  logic                    r_cmp_ie;
  logic                    r_periodic;
  logic                    r_ovf_ie;
  logic                    r_match;
  logic                    r_ovf;
  logic [31:0]             r_rd_shadow;
  logic [31:0]             r_wr_shadow;
  logic                    r_valid;
  logic [31:0]             r_data;

  logic                    w_wr;
  logic                    w_rd;
  logic                    w_clr;
  logic                    w_load;
  logic                    w_w1c;
  logic                    w_tick;
  logic                    w_match_hit;
  logic                    w_ovf_hit;
  logic                    w_ack_clr;
  logic                    w_match_nx;
  logic                    w_ovf_nx;
  logic                    w_irq_cond;
  logic                    w_irq_cond_nx;
  logic [31:0]             w_rd_data;

  assign w_wr   = iREQ & iRW;
  assign w_rd   = iREQ & ~iRW;
  assign w_clr  = w_wr && (iADDR == 3'd0) && iDATA[1];
  assign w_load = w_wr && (iADDR == 3'd2);
  assign w_w1c  = w_wr && (iADDR == 3'd6);

  // Prescaler terminal count gates every counter advance.
  assign w_tick      = r_en && (r_presc == r_div);
  assign w_match_hit = w_tick && r_cmp_en && (r_cnt == r_cmp);
  assign w_ovf_hit   = w_tick && (r_cnt == '1);

  // Acknowledge only means something while the request is visible.
  assign w_ack_clr = (r_state == S_PEND) && iACK;

  // Clears (ACK or W1C) act first, so an event landing in the same cycle survives.
  assign w_match_nx = (r_match & ~w_ack_clr & ~(w_w1c & iDATA[0])) | w_match_hit;
  assign w_ovf_nx   = (r_ovf   & ~w_ack_clr & ~(w_w1c & iDATA[1])) | w_ovf_hit;

  assign w_irq_cond    = (r_match & r_cmp_ie) | (r_ovf & r_ovf_ie);
  assign w_irq_cond_nx = (w_match_nx & r_cmp_ie) | (w_ovf_nx & r_ovf_ie);

  // Control and configuration registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_en        <= 1'b0;
      r_div       <= '0;
      r_cmp       <= '0;
      r_cmp_en    <= 1'b0;
      r_cmp_ie    <= 1'b0;
      r_periodic  <= 1'b0;
      r_ovf_ie    <= 1'b0;
      r_wr_shadow <= '0;
    end else if (w_wr) begin
      case (iADDR)
        3'd0: begin
          r_en  <= iDATA[0];
          r_div <= iDATA[P_PRESCALE_W+7:8];
        end
        3'd1: r_wr_shadow   <= iDATA;
        3'd3: r_cmp[31:0]   <= iDATA;
        3'd4: r_cmp[63:32]  <= iDATA;
        3'd5: begin
          r_cmp_en   <= iDATA[0];
          r_cmp_ie   <= iDATA[1];
          r_periodic <= iDATA[2];
          r_ovf_ie   <= iDATA[3];
        end
        default: ;
      endcase
    end
  end

  // Prescaler and counter: CLR beats a CNT_H load, which beats a tick.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_clr) begin
        r_presc <= '0;
      end else if (r_en) begin
        r_presc <= w_tick ? '0 : r_presc + P_PRESCALE_W'(1);
      end

      if (w_clr) begin
        r_cnt <= '0;
      end else if (w_load) begin
        r_cnt <= {iDATA, r_wr_shadow};
      end else if (w_tick) begin
        // All-ones rolls over to zero through the plain increment.
        r_cnt <= (w_match_hit && r_periodic) ? 64'd0 : r_cnt + 64'd1;
      end
    end
  end

  // Event flags.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_match <= w_match_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  // IRQ state register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // IRQ next state: raise from the registered flags; drop on ACK or when
  // software has cleared every enabled flag.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_irq_cond) begin
          w_state_nx = S_PEND;
        end
      end
      S_PEND: begin
        if (iACK) begin
          w_state_nx = S_IDLE;
        end else if (w_w1c && !w_irq_cond_nx) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign oIRQ = (r_state == S_PEND);

  // Read mux.
  always_comb begin
    w_rd_data = 32'd0;
    case (iADDR)
      3'd0: begin
        w_rd_data[P_PRESCALE_W+7:8] = r_div;
        w_rd_data[0]                = r_en;
      end
      3'd1: w_rd_data = r_cnt[31:0];
      3'd2: w_rd_data = r_rd_shadow;
      3'd3: w_rd_data = r_cmp[31:0];
      3'd4: w_rd_data = r_cmp[63:32];
      3'd5: w_rd_data = {28'd0, r_ovf_ie, r_periodic, r_cmp_ie, r_cmp_en};
      3'd6: w_rd_data = {30'd0, r_ovf, r_match};
      default: w_rd_data = 32'd0;
    endcase
  end

  // Response path and the CNT_L-read upper-word snapshot.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_rd_shadow <= '0;
    end else begin
      r_valid <= iREQ;
      r_data  <= w_rd ? w_rd_data : 32'd0;
      if (w_rd && (iADDR == 3'd1)) begin
        r_rd_shadow <= r_cnt[63:32];
      end
    end
  end

  assign oVALID = r_valid;
  assign oDATA  = r_data;

endmodule

// File: tb/tb_dps_utim64.sv
// tb/tb_dps_utim64.sv - directed self-checking bench for dps_utim64

module tb_dps_utim64;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iREQ;
  logic        iRW;
  logic [2:0]  iADDR;
  logic [31:0] iDATA;
  logic        oVALID;
  logic [31:0] oDATA;
  logic        oIRQ;
  logic        iACK;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 iCLOCK = ~iCLOCK;

  dps_utim64 #(.P_PRESCALE_W(8)) dut (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .iREQ   (iREQ),
    .iRW    (iRW),
    .iADDR  (iADDR),
    .iDATA  (iDATA),
    .oVALID (oVALID),
    .oDATA  (oDATA),
    .oIRQ   (oIRQ),
    .iACK   (iACK)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iCLOCK);
      #1;
    end
  endtask

  // One bus transaction: request is sampled at the next edge, response checked 1 time unit later.
  task automatic bus(input logic rw, input logic [2:0] a, input logic [31:0] d, output logic [31:0] q);
    iREQ  = 1'b1;
    iRW   = rw;
    iADDR = a;
    iDATA = d;
    @(posedge iCLOCK);
    #1;
    iREQ  = 1'b0;
    iRW   = 1'b0;
    iADDR = 3'd0;
    iDATA = 32'd0;
    chk("valid", {63'd0, oVALID}, 64'd1);
    q = oDATA;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, q);
    chk("wr_data_zero", {32'd0, q}, 64'd0);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'd0, q);
  endtask

  logic [31:0] q;
  logic [31:0] t3_cnt  [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
  logic [31:0] t3_flag [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    inRESET = 1'b0;
    iREQ    = 1'b0;
    iRW     = 1'b0;
    iADDR   = 3'd0;
    iDATA   = 32'd0;
    iACK    = 1'b0;

    // Reset values and register readback.
    step(3);
    chk("rst_irq",   {63'd0, oIRQ},   64'd0);
    chk("rst_valid", {63'd0, oVALID}, 64'd0);
    chk("rst_data",  {32'd0, oDATA},  64'd0);
    inRESET = 1'b1;
    step(1);
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], q);
      chk($sformatf("rst_rd_a%0d", a), {32'd0, q}, 64'd0);
    end
    step(1);
    chk("valid_drop", {63'd0, oVALID}, 64'd0);

    // One-shot compare at 5, DIV = 0.
    wr(3'd3, 32'd5);
    wr(3'd4, 32'd0);
    wr(3'd5, 32'h3);
    wr(3'd0, 32'h1);
    step(6);
    chk("t2_irq_pre", {63'd0, oIRQ}, 64'd0);
    step(1);
    chk("t2_irq", {63'd0, oIRQ}, 64'd1);
    iACK = 1'b1;
    step(1);
    iACK = 1'b0;
    chk("t2_ack_drop", {63'd0, oIRQ}, 64'd0);
    rd(3'd6, q);
    chk("t2_flags", {32'd0, q}, 64'd0);
    rd(3'd1, q);
    chk("t2_cnt_cont", {32'd0, q}, 64'd9);

    // Periodic compare at 3, DIV = 1.
    wr(3'd0, 32'h2);
    wr(3'd3, 32'd3);
    wr(3'd5, 32'h5);
    wr(3'd6, 32'h3);
    wr(3'd0, 32'h101);
    for (int i = 0; i < 16; i++) begin
      rd(3'd1, q);
      chk($sformatf("t3_cnt_%0d", i), {32'd0, q}, {32'd0, t3_cnt[i]});
    end
    rd(3'd6, q);
    chk("t3_match", {32'd0, q}, 64'd1);
    wr(3'd6, 32'h1);
    for (int j = 0; j < 8; j++) begin
      rd(3'd6, q);
      chk($sformatf("t3_flag_%0d", j), {32'd0, q}, {32'd0, t3_flag[j]});
    end

    // Overflow through CNT_L/CNT_H load, then W1C drops the IRQ.
    wr(3'd0, 32'h2);
    wr(3'd5, 32'h8);
    wr(3'd6, 32'h3);
    wr(3'd1, 32'hFFFF_FFFE);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd0, 32'h1);
    step(2);
    chk("t4_irq_pre", {63'd0, oIRQ}, 64'd0);
    step(1);
    chk("t4_irq", {63'd0, oIRQ}, 64'd1);
    rd(3'd6, q);
    chk("t4_ovf", {32'd0, q}, 64'd2);
    rd(3'd1, q);
    chk("t4_cnt_l", {32'd0, q}, 64'd2);
    rd(3'd2, q);
    chk("t4_cnt_h", {32'd0, q}, 64'd0);
    wr(3'd6, 32'h2);
    chk("t4_w1c_drop", {63'd0, oIRQ}, 64'd0);

    // Atomic read across a low-word carry.
    wr(3'd0, 32'h2);
    wr(3'd1, 32'hFFFF_FFFD);
    wr(3'd2, 32'h1);
    wr(3'd0, 32'h1);
    step(2);
    rd(3'd1, q);
    chk("t4b_lo", {32'd0, q}, 64'hFFFF_FFFF);
    rd(3'd2, q);
    chk("t4b_hi_shadow", {32'd0, q}, 64'd1);
    rd(3'd1, q);
    chk("t4b_lo2", {32'd0, q}, 64'd1);
    rd(3'd2, q);
    chk("t4b_hi2", {32'd0, q}, 64'd2);

    // ACK coinciding with a new match: one-cycle drop, then reassert.
    wr(3'd0, 32'h2);
    wr(3'd3, 32'd1);
    wr(3'd5, 32'h7);
    wr(3'd6, 32'h3);
    wr(3'd0, 32'h1);
    step(3);
    chk("t5_irq", {63'd0, oIRQ}, 64'd1);
    iACK = 1'b1;
    step(1);
    iACK = 1'b0;
    chk("t5_drop", {63'd0, oIRQ}, 64'd0);
    step(1);
    chk("t5_reassert", {63'd0, oIRQ}, 64'd1);
    rd(3'd6, q);
    chk("t5_match", {32'd0, q}, 64'd1);

    // Asynchronous reset while pending and running.
    chk("t6_irq_before", {63'd0, oIRQ}, 64'd1);
    #2;
    inRESET = 1'b0;
    #1;
    chk("t6_irq_rst",   {63'd0, oIRQ},   64'd0);
    chk("t6_valid_rst", {63'd0, oVALID}, 64'd0);
    chk("t6_data_rst",  {32'd0, oDATA},  64'd0);
    step(2);
    inRESET = 1'b1;
    rd(3'd1, q);
    chk("t6_cnt_l", {32'd0, q}, 64'd0);
    rd(3'd2, q);
    chk("t6_cnt_h", {32'd0, q}, 64'd0);
    rd(3'd6, q);
    chk("t6_flags", {32'd0, q}, 64'd0);
    rd(3'd0, q);
    chk("t6_ctrl", {32'd0, q}, 64'd0);
    rd(3'd5, q);
    chk("t6_cmpctrl", {32'd0, q}, 64'd0);
    step(5);
    rd(3'd1, q);
    chk("t6_stopped", {32'd0, q}, 64'd0);
    chk("t6_irq_after", {63'd0, oIRQ}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dps_utim64.md
Name: dps_utim64

Overview:
- 64-bit free-running user timer with one compare channel and overflow detection.
- Raises a level interrupt request to the DPS interrupt controller and holds it until that controller acknowledges it.
- Programmed by the DPS register bus using single-cycle requests and one-cycle-latency responses.
- Sits directly upstream of the interrupt controller's UTIM64 source input (IRQ/ACK pair).

Parameters:
P_PRESCALE_W, 8, width of prescaler divisor field and prescaler counter.

Ports:
iCLOCK  input  1  system clock, rising edge.
inRESET  input  1  asynchronous active-low reset.
iREQ  input  1  register access request, one-cycle pulse.
iRW  input  1  1 = write, 0 = read.
iADDR  input  3  register index.
iDATA  input  32  write data.
oVALID  output  1  response strobe, one cycle after iREQ.
oDATA  output  32  read data, valid with oVALID; 0 for writes.
oIRQ  output  1  interrupt request level to the interrupt controller.
iACK  input  1  acknowledge from the interrupt controller, single-cycle pulse.

Behaviour:
- Clocking and reset: one clock (iCLOCK); reset inRESET is asynchronous, active-low.
- Values at reset:
  - All registers, counter, prescaler, shadows and flags are 0.
  - oIRQ = 0, oVALID = 0, oDATA = 0.
  - Reset mid-operation aborts everything immediately, including any pending IRQ.
- Register map (iADDR):
  - 0 CTRL: [0] EN, [1] CLR (self-clearing), [P_PRESCALE_W+7:8] DIV.
  - 1 CNT_L.
  - 2 CNT_H.
  - 3 CMP_L.
  - 4 CMP_H.
  - 5 CMPCTRL: [0] CMP_EN, [1] CMP_IE, [2] PERIODIC, [3] OVF_IE.
  - 6 FLAGS: [0] MATCH, [1] OVF; write-1-to-clear.
  - 7: reads 0, writes ignored.
- Bus handshake:
  - iREQ accepted every cycle; no back-pressure.
  - oVALID = iREQ delayed one cycle; oDATA registered in the same cycle as oVALID.
- Atomic 64-bit counter read:
  - Reading CNT_L returns cnt[31:0] and latches cnt[63:32] into a read shadow.
  - Reading CNT_H returns the read shadow, not the live counter.
- Atomic 64-bit counter write:
  - Writing CNT_L stores into a write shadow only.
  - Writing CNT_H loads cnt <= {iDATA, write shadow} on the next edge.
  - This load overrides a same-cycle tick.
- CMP_L and CMP_H write directly to the compare register.
- Prescaler:
  - Counts only while EN = 1.
  - When prescaler == DIV, generate tick and reset prescaler to 0; otherwise increment prescaler.
  - The counter advances once every DIV+1 cycles (DIV = 0 means every cycle).
  - EN = 0 freezes both the prescaler and the counter.
- CLR:
  - Zeroes cnt and the prescaler on the next edge.
  - Has priority over tick and over a CNT_H load.
- Events on a tick:
  - Match: if CMP_EN and cnt == cmp, set MATCH. If PERIODIC, cnt <= 0; otherwise cnt <= cnt + 1.
  - Overflow: cnt == 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 and sets OVF.
  - Match and overflow in the same tick set both flags.
- IRQ state, 1-bit, IDLE/PEND:
  - IDLE -> PEND when (MATCH & CMP_IE) | (OVF & OVF_IE).
  - oIRQ = 1 exactly in PEND.
  - PEND with iACK = 1 clears MATCH and OVF and returns to IDLE on the next edge.
  - iACK is accepted combinationally by the interrupt controller while oIRQ = 1, so the state is registered one cycle later.
  - iACK in IDLE is ignored.
- Simultaneous events:
  - A new flag-setting event in the same cycle as iACK survives the clear: the flag stays 1, and the state re-enters PEND on the following cycle.
  - A software W1C write in the same cycle as a flag-setting event: set wins.
  - Software W1C that clears all enabled flags while in PEND drops oIRQ on the next edge (state -> IDLE).
- Flags set while their IE bit is 0 stay set; setting IE later raises oIRQ.

Test Plan:
- Reset, then read all registers -> every read returns 0; oIRQ = 0; oVALID pulses exactly one cycle after each iREQ.
- CMP = 5, CMP_EN = 1, CMP_IE = 1, DIV = 0, EN = 1 -> MATCH sets on the tick where cnt == 5 and oIRQ rises on the next cycle. Pulse iACK -> oIRQ = 0 one cycle later, FLAGS reads 0, cnt continues 6, 7, ...
- PERIODIC = 1, CMP = 3, DIV = 1 -> cnt sequence 0,1,2,3,0,... with each value lasting 2 cycles; MATCH sets every 8 cycles.
- Write CNT_L = 32'hFFFF_FFFE, then CNT_H = 32'hFFFF_FFFF; OVF_IE = 1 -> after 2 ticks cnt = 0, OVF = 1, oIRQ = 1.
  - Read CNT_L, then CNT_H while a low-word carry occurs between the reads -> the pair is consistent (the upper word is the value latched at the CNT_L read).
- Hold oIRQ with iACK issued in the same cycle as a new match -> oIRQ drops for exactly one cycle, then reasserts; MATCH = 1.
- Assert inRESET while oIRQ = 1 and the counter is running -> oIRQ, cnt and all flags read 0 immediately; the timer stays stopped after release.
